e1_rx_buf_wr: RTL
=================

Name: e1_rx_buf_wr

Overview:
- Downstream consumer of the E1 RX buffer-write strobe interface (data / ts / frame / mf / we / rdy).
- Packs consecutive timeslot bytes into 32-bit words and writes them to the shared frame-buffer memory port through a req/ack handshake.
- Provides backpressure to the RX path, plus drop and word-count status.

Parameters:
- MFW, 7, multiframe index width; must equal the RX core's MFW.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_data  in  8  timeslot byte
- in_ts  in  5  timeslot number 0..31
- in_frame  in  4  frame number within multiframe 0..15
- in_mf  in  MFW  multiframe index
- in_we  in  1  byte write strobe, one cycle per byte
- in_rdy  out  1  block can accept a byte this cycle
- mem_addr  out  MFW+7  word address {mf, frame, ts[4:2]}
- mem_data  out  32  packed word, lane n = bits [8n+7:8n]
- mem_be  out  4  byte enables, bit n = lane n
- mem_req  out  1  write request
- mem_ack  in  1  write accepted, one-cycle pulse
- ctrl_ena  in  1  enable; low discards partial word
- ctrl_flush  in  1  one-cycle pulse, force out partial word
- ctrl_clr  in  1  one-cycle pulse, clears stat_drop
- stat_drop  out  1  sticky: byte strobed while in_rdy low
- stat_words  out  16  count of acked words, wraps 0xFFFF->0

Behaviour:
- Reset values:
  - asm_valid=0, asm_be=0, asm_data=0, asm_addr=0.
  - out_valid=0, so mem_req=0, mem_be=0, mem_data=0, mem_addr=0.
  - stat_drop=0, stat_words=0.
  - in_rdy=1 after reset, but only while ctrl_ena is high.
- Two register stages:
  - Assembly stage: asm_data, asm_be, asm_addr, asm_valid.
  - Output stage: mem_* plus out_valid.
  - mem_req = out_valid.
- in_rdy = ctrl_ena & ~out_valid. Purely combinational from state; no path from mem_ack.
- Accepted byte: the cycle with in_we & in_rdy.
  - lane = in_ts[1:0]; waddr = {in_mf, in_frame, in_ts[4:2]}.
  - Case A, asm_valid & asm_addr != waddr:
    - Old asm moves to the output stage.
    - The new byte starts a fresh asm: be = one-hot(lane), data = byte in its lane, others zero.
  - Case B, otherwise:
    - Byte merges into asm: lane data replaced, be bit set, asm_addr=waddr, asm_valid=1.
    - A repeated lane overwrites the earlier byte.
  - If lane==3 after case A or B and no push occurred this cycle, the merged word moves to the output stage and asm clears.
  - If case A pushed and lane==3: the new single-byte word stays in asm with asm_valid=1. It is pushed on the next accepted byte or by flush. Only one push per cycle.
- Latency: mem_req rises the cycle after the pushing byte is accepted.
- Handshake:
  - mem_addr, mem_data and mem_be are held stable while mem_req is high.
  - On mem_ack: out_valid=0 and stat_words increments, both in the same edge.
  - mem_ack while mem_req is low is ignored.
- ctrl_flush: if asm_valid & ~out_valid, asm is pushed and cleared. If out_valid=1, the flush is ignored (not queued). Flush coinciding with an accepted byte: the byte has priority and the flush is ignored.
- ctrl_ena low:
  - asm is cleared (asm_valid=0, be=0) every cycle and in_rdy=0.
  - A pending output transaction completes normally; mem_req is never withdrawn before mem_ack.
- Drops:
  - in_we & ~in_rdy sets stat_drop; the byte is discarded.
  - ctrl_clr clears stat_drop. If a set and ctrl_clr coincide, set wins.
- Reset asserted mid-transaction: mem_req drops immediately (async). The memory arbiter shares the same reset.

Decomposition:
- Shared E1 header constants: E1_TS_PER_FRAME=32, E1_FRAMES_PER_MF=16, BYTES_PER_WORD=4, and the word-address composition order {mf, frame, ts[4:2]}. The buffer reader on the bus side uses the same constants.
- No sub-module: the assembly and output stages are small enough inline.

Test Plan:
- Basic packing: ctrl_ena=1; bytes ts0..3 = 0x11,0x22,0x33,0x44, frame=2, mf=5, ack 2 cycles after req -> mem_addr={5,2,0}, mem_data=0x44332211, mem_be=0xF, stat_words=1.
- Partial word then address change: ts4=0xAA, ts5=0xBB, then ts12=0xCC -> write data 0x0000BBAA, be=0x3, addr ts-word 1. ts12 is held in asm; ctrl_flush -> data 0x000000CC, be=0x1, addr ts-word 3.
- Backpressure: hold mem_ack low 20 cycles after the first push -> in_rdy=0 throughout. A byte strobed then sets stat_drop=1 and produces no write. ctrl_clr -> stat_drop=0.
- Enable drop: bytes ts0..1, then ctrl_ena=0 for 1 cycle, then ts2..3 -> single write with be=0xC. Earlier bytes discarded, no extra request.
- Wrap: preload 65535 acks -> stat_words=0xFFFF; one more ack -> 0x0000.
- Async reset with mem_req high -> mem_req=0 the same cycle; after release in_rdy=1 and no stale write.

Source files
------------

// File: rtl/e1_rx_buf_wr_pkg.sv
// Shared E1 frame-buffer constants and helper types for the RX buffer writer.
// The bus-side buffer reader uses the same word-address layout {mf, frame, ts[4:2]}.
package e1_rx_buf_wr_pkg;

  localparam int E1_TS_PER_FRAME  = 32;
  localparam int E1_FRAMES_PER_MF = 16;
  localparam int BYTES_PER_WORD   = 4;

  localparam int TS_W       = $clog2(E1_TS_PER_FRAME);
  localparam int FRAME_W    = $clog2(E1_FRAMES_PER_MF);
  localparam int LANE_W     = $clog2(BYTES_PER_WORD);
  localparam int WSEL_W     = TS_W - LANE_W;
  localparam int ADDR_LO_W  = FRAME_W + WSEL_W;
  localparam int WORD_W     = 8 * BYTES_PER_WORD;

  typedef struct packed {
    logic [WORD_W-1:0]         data;
    logic [BYTES_PER_WORD-1:0] be;
  } word_t;

  function automatic logic [BYTES_PER_WORD-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    return {{(BYTES_PER_WORD-1){1'b0}}, 1'b1} << lane;
  endfunction

endpackage

// File: rtl/e1_rx_buf_wr_if.sv
// Bundle of the RX byte strobe, memory write port, control and status signals.
// slave = the buffer writer's view, master = the surrounding system's view.
interface e1_rx_buf_wr_if
  import e1_rx_buf_wr_pkg::*;
#(
  parameter int MFW = 7
);
  localparam int AW = MFW + ADDR_LO_W;

  logic [7:0]                in_data;
  logic [TS_W-1:0]           in_ts;
  logic [FRAME_W-1:0]        in_frame;
  logic [MFW-1:0]            in_mf;
  logic                      in_we;
  logic                      in_rdy;

  logic [AW-1:0]             mem_addr;
  logic [WORD_W-1:0]         mem_data;
  logic [BYTES_PER_WORD-1:0] mem_be;
  logic                      mem_req;
  logic                      mem_ack;

  logic                      ctrl_ena;
  logic                      ctrl_flush;
  logic                      ctrl_clr;
  logic                      stat_drop;
  logic [15:0]               stat_words;

  modport slave (
    input  in_data, in_ts, in_frame, in_mf, in_we, mem_ack, ctrl_ena, ctrl_flush, ctrl_clr,
    output in_rdy, mem_addr, mem_data, mem_be, mem_req, stat_drop, stat_words
  );

  modport master (
    output in_data, in_ts, in_frame, in_mf, in_we, mem_ack, ctrl_ena, ctrl_flush, ctrl_clr,
    input  in_rdy, mem_addr, mem_data, mem_be, mem_req, stat_drop, stat_words
  );

endinterface

// File: rtl/e1_rx_buf_wr.sv
// Packs E1 timeslot bytes into 32-bit words (assembly stage) and writes them to the
// frame buffer through a single-entry req/ack output stage.
module e1_rx_buf_wr
  import e1_rx_buf_wr_pkg::*;
#(
  parameter int MFW = 7
) (
  input logic           clk,
  input logic           rst,
  e1_rx_buf_wr_if.slave bus
);
  localparam int AW = MFW + ADDR_LO_W;

  word_t         asm_q, asm_d, merged;
  logic [AW-1:0] asm_addr_q, asm_addr_d;
  logic          asm_valid_q, asm_valid_d;
  word_t         out_q, out_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic          out_valid_q, out_valid_d;
  logic          drop_q, drop_d;
  logic [15:0]   words_q, words_d;

  logic              in_rdy;
  logic              accept;
  logic [LANE_W-1:0] lane;
  logic [AW-1:0]     waddr;

  // Ready depends only on state so the RX path never sees a combinational path from mem_ack.
  assign in_rdy = bus.ctrl_ena & ~out_valid_q;
  assign accept = bus.in_we & in_rdy;
  assign lane   = bus.in_ts[LANE_W-1:0];
  assign waddr  = {bus.in_mf, bus.in_frame, bus.in_ts[TS_W-1:LANE_W]};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    asm_d       = asm_q;
    asm_addr_d  = asm_addr_q;
    asm_valid_d = asm_valid_q;
    out_d       = out_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    drop_d      = drop_q;
    words_d     = words_q;

    merged                     = asm_q;
    merged.data[{lane, 3'b000} +: 8] = bus.in_data;
    merged.be[lane]            = 1'b1;

    if (out_valid_q && bus.mem_ack) begin
      out_valid_d = 1'b0;
      words_d     = words_q + 16'd1;
    end

    if (bus.ctrl_clr)             drop_d = 1'b0;
    if (bus.in_we && !in_rdy)     drop_d = 1'b1;

    if (!bus.ctrl_ena) begin
      asm_d       = '0;
      asm_addr_d  = '0;
      asm_valid_d = 1'b0;
    end else if (accept) begin
      if (asm_valid_q && (asm_addr_q != waddr)) begin
        // Address change: old word leaves, new byte (even lane 3) waits in asm.
        out_d       = asm_q;
        out_addr_d  = asm_addr_q;
        out_valid_d = 1'b1;
        asm_d.data  = {{(WORD_W-8){1'b0}}, bus.in_data} << {lane, 3'b000};
        asm_d.be    = lane_onehot(lane);
        asm_addr_d  = waddr;
        asm_valid_d = 1'b1;
      end else if (lane == LANE_W'(BYTES_PER_WORD - 1)) begin
        out_d       = merged;
        out_addr_d  = waddr;
        out_valid_d = 1'b1;
        asm_d       = '0;
        asm_addr_d  = '0;
        asm_valid_d = 1'b0;
      end else begin
        asm_d       = merged;
        asm_addr_d  = waddr;
        asm_valid_d = 1'b1;
      end
    end else if (bus.ctrl_flush && asm_valid_q && !out_valid_q) begin
      out_d       = asm_q;
      out_addr_d  = asm_addr_q;
      out_valid_d = 1'b1;
      asm_d       = '0;
      asm_addr_d  = '0;
      asm_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q       <= '0;
      asm_addr_q  <= '0;
      asm_valid_q <= 1'b0;
      out_q       <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      asm_q       <= asm_d;
      asm_addr_q  <= asm_addr_d;
      asm_valid_q <= asm_valid_d;
      out_q       <= out_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      words_q     <= words_d;
    end
  end

  assign bus.in_rdy     = in_rdy;
  assign bus.mem_req    = out_valid_q;
  assign bus.mem_addr   = out_addr_q;
  assign bus.mem_data   = out_q.data;
  assign bus.mem_be     = out_q.be;
  assign bus.stat_drop  = drop_q;
  assign bus.stat_words = words_q;

endmodule
